tcp_send_engine: RTL and testbench
==================================

Name: tcp_send_engine

Overview:
- Benchmark traffic generator for the TCP/IP offload TX path; the transmit counterpart of the TCP RX benchmark checker.
- Issues `ops` TCP send requests of `tcp_length` bytes each on one session.
- Each request streams a counting pattern that the RX checker validates: word index + offset in `data[31:0]`.
- Reports cycle count, completed ops, words sent and retries through `status_reg`.

Parameters:
- DATA_WIDTH, 512, `m_axis_tx_data` width in bits; one word is 64 bytes.
- RETRY_GAP, 16, idle cycles before re-issuing metadata after a TX error status.

Ports:
- clk  input  1  core clock.
- rstn  input  1  reset, asynchronous, active-low.
- m_axis_tx_metadata  axis_meta.master  32  send request; `data = {16'length_bytes, 16'session_id}`.
- s_axis_tx_status  axis_meta.slave  64  TX status; `data[63:62]` = error code, 0 = OK.
- m_axis_tx_data  axi_stream.master  DATA_WIDTH  payload; keep is all ones, last marks the final word of an op.
- control_reg  input  16x32  [0] bit0 start, [1] tcp_length in bytes, [2] ops, [3] offset, [4] bits[15:0] session_id.
- status_reg  output  8x32  [0] th_cnt, [1] ops_done, [2] words_sent, [3] flags, [4] retry_cnt, [7:5] zero.

Behaviour:
- control_reg[1..4] are registered every cycle.
- `words_per_op = tcp_length >> 6` (32-bit, truncating); the low 6 bits of tcp_length are ignored.
- Metadata length field = `tcp_length[15:0]`.
- start is rising-edge detected with a 2-flop register.
- At the start edge the configuration is latched and held for the whole run.
- Start is accepted only in IDLE or DONE; it is ignored while busy.
- Config error: start with `words_per_op == 0` or `ops == 0` sets `cfg_err`, which stays set until the next accepted start. The FSM stays idle.
- State machine:
  - IDLE: all valids low. On accepted start, clear ops_done, words_sent, retry_cnt and th_cnt, then go to META.
  - META: `m_axis_tx_metadata.valid = 1`; data stays stable until ready.
    - On handshake with the macro defined: go to WAIT_ST.
    - On handshake without the macro: go to DATA.
  - WAIT_ST: `s_axis_tx_status.ready = 1`.
    - Error == 0: go to DATA.
    - Error != 0: retry_cnt++, wait RETRY_GAP cycles in GAP, then return to META for the same op.
  - DATA: `m_axis_tx_data.valid = 1`.
    - `data[31:0] = word_idx + offset` (mod 2^32); upper bits zero.
    - On each handshake: word_idx++ and words_sent++.
    - `last = (word_idx == words_per_op-1)`.
    - On the last handshake: word_idx = 0 and ops_done++. If ops_done+1 == ops, go to DONE; otherwise go to META.
  - DONE: valids low; done flag = 1; wait for the next start.
- Valid and data are registered outputs; valid never drops before its handshake.
- Back-to-back words are allowed: one word per cycle while ready = 1.
- Zero idle cycles between DATA and the next META handshake are not required. Each transition costs exactly one cycle.
- th_cnt increments on every cycle from the first META cycle through the cycle of the final data handshake inclusive; it then holds.
- Counters wrap modulo 2^32 without saturation.
- status_reg[3] flags: bit0 busy (not IDLE/DONE), bit1 done, bit2 cfg_err, bits[7:4] state encoding.
- Reset at any time, including mid-packet:
  - All state returns to IDLE, all counters and flags clear, and all valids drop asynchronously.
  - No partial-packet completion is attempted.
- Reset values of outputs: every valid 0, data 0, last 0, `s_axis_tx_status.ready` 0, status_reg all 0.

Optional Feature:
- TCP_SEND_TX_STATUS_EN
- Defined: WAIT_ST and GAP states exist.
  - Each op waits for a TX status before payload.
  - Error statuses cause retry after RETRY_GAP, and retry_cnt counts them.
- Undefined: META goes directly to DATA.
  - `s_axis_tx_status.ready` is tied to 1 and the status is discarded.
  - retry_cnt reads 0.

Test Plan:
- tcp_length=256, ops=3, offset=0x100, session=5, always-ready sinks -> 3 metadata words `0x01000005`; data[31:0] per op = 0x100, 0x101, 0x102, 0x103; last on the 4th word; ops_done=3, words_sent=12, done=1.
- Same configuration with random ready backpressure on both masters -> identical data sequence; valid and data held stable while ready = 0; no dropped or duplicated words.
- TCP_SEND_TX_STATUS_EN, first status error=1 and the rest OK, RETRY_GAP=16 -> metadata re-sent ≥16 cycles after the error status; retry_cnt=1; total payload still 12 words.
- tcp_length=32 or ops=0, then pulse start -> no valids ever asserted; cfg_err=1; busy=0.
- Assert rstn low in the middle of op 2 of 3 -> valids low immediately; status_reg all 0; a new start runs a full 3-op sequence from word_idx 0.
- offset=0xFFFFFFFE, tcp_length=256, ops=1 -> data[31:0] = 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap); start pulsed mid-run is ignored.

Source files
------------

// File: rtl/tcp_send_engine.sv
// tcp_send_engine
//   Benchmark traffic generator for the TCP offload TX path. Issues `ops`
//   send requests of `tcp_length` bytes on one session; each request streams
//   a counting pattern (word index + offset in data[31:0]) that the RX
//   benchmark checker validates.
//
// Ports
//   clk, rstn                    core clock, async active-low reset
//   m_axis_tx_metadata_*         send request, data = {length[15:0], session}
//   s_axis_tx_status_*           TX status, data[63:62] = error code (0 = OK)
//   m_axis_tx_data_*             payload stream, keep all ones, last per op
//   control_reg  (16x32 flat)    [0] bit0 start, [1] tcp_length, [2] ops,
//                                [3] offset, [4] bits[15:0] session_id
//   status_reg   (8x32 flat)     [0] th_cnt, [1] ops_done, [2] words_sent,
//                                [3] flags, [4] retry_cnt, [7:5] zero
//
// Build option
//   TCP_SEND_TX_STATUS_EN  each op waits for a TX status before payload;
//                          error statuses are retried after RETRY_GAP idle
//                          cycles. Undefined: status is accepted and dropped.
module tcp_send_engine #(
    parameter int DATA_WIDTH = 512,
    parameter int RETRY_GAP  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    m_axis_tx_metadata_valid,
    input  logic                    m_axis_tx_metadata_ready,
    output logic [31:0]             m_axis_tx_metadata_data,
    input  logic                    s_axis_tx_status_valid,
    output logic                    s_axis_tx_status_ready,
    input  logic [63:0]             s_axis_tx_status_data,
    output logic                    m_axis_tx_data_valid,
    input  logic                    m_axis_tx_data_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_tx_data_data,
    output logic [DATA_WIDTH/8-1:0] m_axis_tx_data_keep,
    output logic                    m_axis_tx_data_last,
    input  logic [511:0]            control_reg,
    output logic [255:0]            status_reg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_META = 4'd1,
        S_WAIT = 4'd2,
        S_GAP  = 4'd3,
        S_DATA = 4'd4,
        S_DONE = 4'd5
    } state_t;

    state_t      state;
    logic [1:0]  start_q;
    logic [31:0] len_q, ops_q, off_q;
    logic [15:0] sess_q;
    logic [31:0] run_wpo, run_ops, run_off;
    logic [31:0] word_idx, tx_word;
    logic [31:0] th_cnt, ops_done, words_sent, retry_cnt;
    logic        cfg_err, meta_vld, data_vld, data_last, st_rdy;
    logic [31:0] meta_word;

    logic        start_edge, busy, done, data_hs;
    logic [31:0] wnext, cfg_wpo;

    assign start_edge = start_q[0] & ~start_q[1];
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign data_hs    = data_vld & m_axis_tx_data_ready;
    assign wnext      = word_idx + 32'd1;
    assign cfg_wpo    = len_q >> 6;

`ifdef TCP_SEND_TX_STATUS_EN
    logic [15:0] gap_cnt;
    logic        st_hs;
    assign st_hs = st_rdy & s_axis_tx_status_valid;
    logic unused_in;
    assign unused_in = ^{control_reg[511:144], control_reg[31:1],
                         s_axis_tx_status_data[61:0]};
`else
    // Status is never inspected; ready comes up one cycle after reset
    // release and stays high so the status channel never backs up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st_rdy <= 1'b0;
        else       st_rdy <= 1'b1;
    end
    logic unused_in;
    assign unused_in = ^{control_reg[511:144], control_reg[31:1],
                         s_axis_tx_status_data, s_axis_tx_status_valid};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            start_q    <= '0;
            len_q      <= '0;
            ops_q      <= '0;
            off_q      <= '0;
            sess_q     <= '0;
            run_wpo    <= '0;
            run_ops    <= '0;
            run_off    <= '0;
            word_idx   <= '0;
            tx_word    <= '0;
            th_cnt     <= '0;
            ops_done   <= '0;
            words_sent <= '0;
            retry_cnt  <= '0;
            cfg_err    <= 1'b0;
            meta_vld   <= 1'b0;
            meta_word  <= '0;
            data_vld   <= 1'b0;
            data_last  <= 1'b0;
`ifdef TCP_SEND_TX_STATUS_EN
            st_rdy     <= 1'b0;
            gap_cnt    <= '0;
`endif
        end else begin
            start_q <= {start_q[0], control_reg[0]};
            len_q   <= control_reg[63:32];
            ops_q   <= control_reg[95:64];
            off_q   <= control_reg[127:96];
            sess_q  <= control_reg[143:128];

            // Counts from the first META cycle through the final data
            // handshake; DONE is not busy so the count freezes there.
            if (busy) th_cnt <= th_cnt + 32'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        if (cfg_wpo == 32'd0 || ops_q == 32'd0) begin
                            cfg_err <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            cfg_err    <= 1'b0;
                            run_wpo    <= cfg_wpo;
                            run_ops    <= ops_q;
                            run_off    <= off_q;
                            meta_word  <= {len_q[15:0], sess_q};
                            word_idx   <= '0;
                            th_cnt     <= '0;
                            ops_done   <= '0;
                            words_sent <= '0;
                            retry_cnt  <= '0;
                            meta_vld   <= 1'b1;
                            state      <= S_META;
                        end
                    end
                end
                S_META: begin
                    if (m_axis_tx_metadata_ready) begin
                        meta_vld <= 1'b0;
`ifdef TCP_SEND_TX_STATUS_EN
                        st_rdy   <= 1'b1;
                        state    <= S_WAIT;
`else
                        data_vld  <= 1'b1;
                        tx_word   <= run_off;
                        data_last <= (run_wpo == 32'd1);
                        state     <= S_DATA;
`endif
                    end
                end
`ifdef TCP_SEND_TX_STATUS_EN
                S_WAIT: begin
                    if (st_hs) begin
                        st_rdy <= 1'b0;
                        if (s_axis_tx_status_data[63:62] == 2'd0) begin
                            data_vld  <= 1'b1;
                            tx_word   <= run_off;
                            data_last <= (run_wpo == 32'd1);
                            state     <= S_DATA;
                        end else begin
                            retry_cnt <= retry_cnt + 32'd1;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // RETRY_GAP full cycles spent here before META re-issues
                    gap_cnt <= gap_cnt + 16'd1;
                    if (gap_cnt == 16'(RETRY_GAP - 1)) begin
                        meta_vld <= 1'b1;
                        state    <= S_META;
                    end
                end
`endif
                S_DATA: begin
                    if (data_hs) begin
                        words_sent <= words_sent + 32'd1;
                        if (data_last) begin
                            word_idx  <= '0;
                            ops_done  <= ops_done + 32'd1;
                            data_vld  <= 1'b0;
                            data_last <= 1'b0;
                            if (ops_done + 32'd1 == run_ops) begin
                                state <= S_DONE;
                            end else begin
                                meta_vld <= 1'b1;
                                state    <= S_META;
                            end
                        end else begin
                            word_idx  <= wnext;
                            tx_word   <= wnext + run_off;
                            data_last <= (wnext == run_wpo - 32'd1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tx_metadata_valid = meta_vld;
    assign m_axis_tx_metadata_data  = meta_word;
    assign s_axis_tx_status_ready   = st_rdy;
    assign m_axis_tx_data_valid     = data_vld;
    assign m_axis_tx_data_data      = {{(DATA_WIDTH-32){1'b0}}, tx_word};
    assign m_axis_tx_data_keep      = '1;
    assign m_axis_tx_data_last      = data_last;

    assign status_reg = {96'd0,
                         retry_cnt,
                         {24'd0, state, 1'b0, cfg_err, done, busy},
                         words_sent,
                         ops_done,
                         th_cnt};

endmodule

// File: tb/tb_tcp_send_engine.sv
// Self-checking bench for tcp_send_engine: directed and randomized runs are
// compared against an expected word/metadata list built from the config.
module tb_tcp_send_engine;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            mv, mr, sv, sr, dv, dr, dl;
    logic [31:0]     md;
    logic [63:0]     sd;
    logic [DW-1:0]   dd;
    logic [DW/8-1:0] dk;
    logic [511:0]    ctrl;
    logic [255:0]    st;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bp_mode = 0;   // 0 always ready, 1 random, 2 data sink stalled
    int err_idx = -1;

    logic [31:0] obs_meta[$];
    int          obs_meta_cyc[$];
    logic [32:0] obs_data[$];   // {last, data[31:0]}
    int          obs_st_cyc[$];
    int          stab_err = 0, fmt_err = 0, valid_cycles = 0;
    logic        p_mv = 0, p_mr = 0, p_dv = 0, p_dr = 0;
    logic [31:0] p_md = '0;
    logic [DW-1:0] p_dd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcp_send_engine #(.DATA_WIDTH(DW), .RETRY_GAP(16)) dut (
        .clk(clk), .rstn(rstn),
        .m_axis_tx_metadata_valid(mv), .m_axis_tx_metadata_ready(mr),
        .m_axis_tx_metadata_data(md),
        .s_axis_tx_status_valid(sv), .s_axis_tx_status_ready(sr),
        .s_axis_tx_status_data(sd),
        .m_axis_tx_data_valid(dv), .m_axis_tx_data_ready(dr),
        .m_axis_tx_data_data(dd), .m_axis_tx_data_keep(dk),
        .m_axis_tx_data_last(dl),
        .control_reg(ctrl), .status_reg(st)
    );

    // Inputs change at posedge+1, so the negedge sees the exact values the
    // next posedge will use for handshakes.
    always @(negedge clk) begin
        if (mv && mr) begin
            obs_meta.push_back(md);
            obs_meta_cyc.push_back(cyc);
        end
        if (dv && dr) begin
            obs_data.push_back({dl, dd[31:0]});
            if (dd[DW-1:32] != '0 || dk != '1) fmt_err <= fmt_err + 1;
        end
        if (sv && sr) obs_st_cyc.push_back(cyc);
        if (mv || dv) valid_cycles <= valid_cycles + 1;
        if (rstn) begin
            if (p_mv && !p_mr && (!mv || md !== p_md)) stab_err <= stab_err + 1;
            if (p_dv && !p_dr && (!dv || dd !== p_dd)) stab_err <= stab_err + 1;
        end
        p_mv <= mv && rstn; p_mr <= mr; p_md <= md;
        p_dv <= dv && rstn; p_dr <= dr; p_dd <= dd;
    end

    initial begin
        mr = 1'b0;
        dr = 1'b0;
        forever begin
            @(posedge clk); #1;
            mr = (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            dr = (bp_mode == 0) ? 1'b1 :
                 (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

`ifdef TCP_SEND_TX_STATUS_EN
    // One status per accepted metadata; the err_idx-th status carries error 1.
    initial begin
        int served, seen;
        served = 0; seen = 0;
        sv = 1'b0; sd = '0;
        forever begin
            @(posedge clk); #1;
            if (sv && obs_st_cyc.size() > seen) begin
                sv = 1'b0;
                seen = obs_st_cyc.size();
            end
            if (!sv && obs_meta.size() > served) begin
                sv = 1'b1;
                sd = {(served == err_idx) ? 2'd1 : 2'd0, 62'd0};
                served++;
            end
        end
    end
`else
    initial begin
        sv = 1'b0;
        sd = '0;
    end
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] len, input logic [31:0] ops,
                           input logic [31:0] off, input logic [15:0] sess);
        ctrl[63:32]   = len;
        ctrl[95:64]   = ops;
        ctrl[127:96]  = off;
        ctrl[143:128] = sess;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        ctrl[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ctrl[0] = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (st[97] !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " done reached"}, 64'(st[97]), 64'd1);
    endtask

    // Expected behaviour from the config alone: ops metadata words, then per op
    // words off+0 .. off+wpo-1 with last on the final one.
    task automatic check_run(input string tag, input int mbase, input int dbase,
                             input logic [31:0] len, input logic [31:0] ops,
                             input logic [31:0] off, input logic [15:0] sess,
                             input bit chk_th);
        logic [31:0] wpo;
        int k;
        wpo = len >> 6;
        check({tag, " meta count"}, 64'(obs_meta.size() - mbase), 64'(ops));
        for (int i = 0; i < int'(ops) && mbase + i < obs_meta.size(); i++)
            check({tag, " meta word"}, 64'(obs_meta[mbase + i]), 64'({len[15:0], sess}));
        check({tag, " data count"}, 64'(obs_data.size() - dbase), 64'(ops * wpo));
        k = dbase;
        for (int o = 0; o < int'(ops); o++)
            for (int i = 0; i < int'(wpo); i++) begin
                if (k < obs_data.size())
                    check({tag, " data word"}, 64'(obs_data[k]),
                          64'({(i == int'(wpo) - 1), off + 32'(i)}));
                k++;
            end
        check({tag, " ops_done"},   64'(st[63:32]), 64'(ops));
        check({tag, " words_sent"}, 64'(st[95:64]), 64'(ops * wpo));
        check({tag, " flags busy/done/cfg_err"}, 64'(st[98:96]), 64'(3'b010));
`ifndef TCP_SEND_TX_STATUS_EN
        if (chk_th) check({tag, " th_cnt"}, 64'(st[31:0]), 64'(ops * (wpo + 1)));
`endif
    endtask

    initial begin
        int mb, db, vb, sb;
        logic [31:0] len, ops, off;
        logic [15:0] sess;
        int n;
        ctrl = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset meta valid",   64'(mv), 64'd0);
        check("reset data valid",   64'(dv), 64'd0);
        check("reset data/last",    64'({dl, |dd}), 64'd0);
        check("reset status ready", 64'(sr), 64'd0);
        check("reset status_reg",   64'(|st), 64'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic run, always-ready sinks
        set_cfg(256, 3, 32'h100, 5);
        bp_mode = 0;
        mb = obs_meta.size(); db = obs_data.size();
        pulse_start();
        wait_done("basic", 500);
        check_run("basic", mb, db, 256, 3, 32'h100, 5, 1'b1);
        check("basic meta literal", 64'(obs_meta[mb]), 64'h01000005);
        check("basic retry_cnt", 64'(st[159:128]), 64'd0);
        check("basic format", 64'(fmt_err), 64'd0);

        // Same config under random backpressure
        bp_mode = 1;
        mb = obs_meta.size(); db = obs_data.size(); sb = stab_err;
        pulse_start();
        wait_done("backpressure", 2000);
        check_run("backpressure", mb, db, 256, 3, 32'h100, 5, 1'b0);
        check("backpressure stability", 64'(stab_err - sb), 64'd0);
        bp_mode = 0;

`ifdef TCP_SEND_TX_STATUS_EN
        // First status of the run carries an error -> one retry
        err_idx = obs_meta.size();
        mb = obs_meta.size(); db = obs_data.size(); sb = obs_st_cyc.size();
        pulse_start();
        wait_done("retry", 1000);
        check("retry retry_cnt", 64'(st[159:128]), 64'd1);
        check("retry words_sent", 64'(st[95:64]), 64'd12);
        check("retry data count", 64'(obs_data.size() - db), 64'd12);
        check("retry meta count", 64'(obs_meta.size() - mb), 64'd4);
        if (obs_meta.size() > mb + 1 && obs_st_cyc.size() > sb)
            check("retry gap >= 16", 64'(obs_meta_cyc[mb + 1] - obs_st_cyc[sb] >= 16), 64'd1);
        err_idx = -1;
`endif

        // Config errors: too short, then zero ops
        vb = valid_cycles;
        set_cfg(32, 3, 0, 5);
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("cfg len valids", 64'(valid_cycles - vb), 64'd0);
        check("cfg len cfg_err/busy", 64'({st[98], st[96]}), 64'(2'b10));
        set_cfg(256, 0, 0, 5);
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("cfg ops valids", 64'(valid_cycles - vb), 64'd0);
        check("cfg ops cfg_err/busy", 64'({st[98], st[96]}), 64'(2'b10));

        // Reset in the middle of op 2, then a clean full run
        set_cfg(256, 3, 32'h100, 5);
        pulse_start();
        n = 0;
        while (st[95:64] != 32'd5 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("midreset reached op 2", 64'(st[95:64]), 64'd5);
        rstn = 1'b0;
        #1;
        check("midreset valids low", 64'({mv, dv}), 64'd0);
        check("midreset status_reg", 64'(|st), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        mb = obs_meta.size(); db = obs_data.size();
        pulse_start();
        wait_done("after reset", 500);
        check_run("after reset", mb, db, 256, 3, 32'h100, 5, 1'b1);

        // Offset wrap; start pulsed while stalled must be ignored
        set_cfg(256, 1, 32'hFFFF_FFFE, 9);
        bp_mode = 2;
        mb = obs_meta.size(); db = obs_data.size();
        pulse_start();
        n = 0;
        while (dv !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wrap stalled in data", 64'(dv), 64'd1);
        pulse_start();
        check("wrap still busy", 64'(st[96]), 64'd1);
        bp_mode = 0;
        wait_done("wrap", 500);
        check_run("wrap", mb, db, 256, 1, 32'hFFFF_FFFE, 9, 1'b0);

        // Randomized configurations
        for (int r = 0; r < 6; r++) begin
            len  = 32'(64 * $urandom_range(1, 5) + $urandom_range(0, 63));
            ops  = 32'($urandom_range(1, 4));
            off  = $urandom;
            sess = 16'($urandom);
            bp_mode = (r % 2);
            set_cfg(len, ops, off, sess);
            mb = obs_meta.size(); db = obs_data.size(); sb = stab_err;
            pulse_start();
            wait_done("random", 3000);
            check_run("random", mb, db, len, ops, off, sess, bp_mode == 0);
            check("random stability", 64'(stab_err - sb), 64'd0);
        end
        check("final format", 64'(fmt_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
